// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler that shares one fixed-point adder among N_REQ requesters.
// Each accepted operand pair is added once and its result is held until the consumer takes it.
module fp_add_scheduler #(
  parameter int N_REQ = 4,
  parameter int W     = 16,
  parameter int W_F   = 14,
  parameter int SAT   = 1,
  localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [W-1:0]       rsp_sum,
  output logic [IDW-1:0]     rsp_id,
  output logic               rsp_overflow,
  output logic               rsp_underflow,
  output logic [15:0]        ovf_count,
  output logic               busy
);

  // The binary point position does not change the arithmetic; this block is intentionally empty.
  if (W_F >= W) begin : g_wf_range_note
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [15:0]      ovf_count_q, ovf_count_d;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [W-1:0]     raw_sum;
  logic             add_ovf;
  logic             add_unf;
  logic [W-1:0]     clipped_sum;

  // Search starts one past the last accepted requester so every requester gets a turn.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    raw_sum     = a_q + b_q;
    add_ovf     = ~a_q[W-1] & ~b_q[W-1] &  raw_sum[W-1];
    add_unf     =  a_q[W-1] &  b_q[W-1] & ~raw_sum[W-1];
    clipped_sum = raw_sum;
    if (SAT != 0) begin
      if (add_ovf) begin
        clipped_sum = {1'b0, {(W-1){1'b1}}};
      end else if (add_unf) begin
        clipped_sum = {1'b1, {(W-1){1'b0}}};
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    sum_d        = sum_q;
    rsp_id_d     = rsp_id_q;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    ovf_count_d  = ovf_count_q;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          a_d          = req_a[grant_idx*W +: W];
          b_d          = req_b[grant_idx*W +: W];
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          state_d      = ADD;
        end
      end
      ADD: begin
        sum_d    = clipped_sum;
        rsp_id_d = id_q;
        ovf_d    = add_ovf;
        unf_d    = add_unf;
        if ((add_ovf || add_unf) && (ovf_count_q != 16'hFFFF)) begin
          ovf_count_d = ovf_count_q + 16'd1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (reset) begin
      req_ready = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(N_REQ - 1);
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      sum_q        <= '0;
      rsp_id_q     <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      ovf_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      sum_q        <= sum_d;
      rsp_id_q     <= rsp_id_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  assign rsp_valid     = (state_q == RESP);
  assign busy          = (state_q != IDLE);
  assign rsp_sum       = sum_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_overflow  = ovf_q;
  assign rsp_underflow = unf_q;
  assign ovf_count     = ovf_count_q;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Self-checking bench for fp_add_scheduler: directed scenarios plus randomized traffic
// compared against an integer-arithmetic reference model with a round-robin pointer.
module tb_fp_add_scheduler;
  localparam int N = 4;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic          rsp_ready;

  logic [N-1:0]  req_ready;
  logic          rsp_valid;
  logic [W-1:0]  rsp_sum;
  logic [1:0]    rsp_id;
  logic          rsp_overflow, rsp_underflow;
  logic [15:0]   ovf_count;
  logic          busy;

  logic [N-1:0]  w_ready;
  logic          w_valid;
  logic [W-1:0]  w_sum;
  logic [1:0]    w_id;
  logic          w_ovf, w_unf;
  logic [15:0]   w_count;
  logic          w_busy;

  fp_add_scheduler #(.N_REQ(N), .W(W), .W_F(14), .SAT(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_id(rsp_id), .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow),
    .ovf_count(ovf_count), .busy(busy)
  );

  fp_add_scheduler #(.N_REQ(N), .W(W), .W_F(14), .SAT(0)) dut_wrap (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(w_ready), .rsp_valid(w_valid), .rsp_ready(rsp_ready), .rsp_sum(w_sum),
    .rsp_id(w_id), .rsp_overflow(w_ovf), .rsp_underflow(w_unf),
    .ovf_count(w_count), .busy(w_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_last = N - 1;
  int m_count = 0;
  int last_hs = 0;
  int hs_gap = 0;
  logic [1:0] obs_id;

  always @(posedge clk) cyc++;

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input bit sat,
                                  output logic [W-1:0] s, output bit o, output bit u);
    int t;
    logic [31:0] tv;
    t  = int'($signed(a)) + int'($signed(b));
    tv = t;
    o  = (t > 32767);
    u  = (t < -32768);
    if (sat && o)      s = 16'h7FFF;
    else if (sat && u) s = 16'h8000;
    else               s = tv[15:0];
  endfunction

  task automatic run_txn(input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                         input int hold, input bit keep_valid);
    int w;
    logic [W-1:0] ea, eb, es, ews;
    bit eo, eu, wo, wu;
    logic [N-1:0] eg;
    @(negedge clk);
    req_valid = v; req_a = a; req_b = b; rsp_ready = 1'b0;
    #1;
    w  = rr_pick(v, m_last);
    eg = '0;
    eg[w] = 1'b1;
    checks++;
    if (req_ready !== eg || w_ready !== eg) begin
      errors++;
      $display("[TB] FAIL grant: req_ready=%b wrap=%b expected %b", req_ready, w_ready, eg);
    end
    ea = a[w*W +: W];
    eb = b[w*W +: W];
    ref_add(ea, eb, 1'b1, es, eo, eu);
    ref_add(ea, eb, 1'b0, ews, wo, wu);
    m_last = w;
    if ((eo || eu) && m_count < 65535) m_count++;
    hs_gap  = cyc - last_hs;
    last_hs = cyc;

    @(negedge clk);
    if (!keep_valid) req_valid = '0;
    #1;
    checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_cycle: req_ready=%b rsp_valid=%b busy=%b expected 0000/0/1",
               req_ready, rsp_valid, busy);
    end

    @(negedge clk);
    #1;
    obs_id = rsp_id;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== es || rsp_id !== 2'(w) ||
        rsp_overflow !== eo || rsp_underflow !== eu || ovf_count !== 16'(m_count)) begin
      errors++;
      $display("[TB] FAIL result: valid=%b sum=%h id=%0d ovf=%b unf=%b cnt=%0d expected 1 %h %0d %b %b %0d",
               rsp_valid, rsp_sum, rsp_id, rsp_overflow, rsp_underflow, ovf_count,
               es, w, eo, eu, m_count);
    end
    checks++;
    if (w_valid !== 1'b1 || w_sum !== ews || w_ovf !== wo || w_unf !== wu || w_id !== 2'(w)) begin
      errors++;
      $display("[TB] FAIL wrap_result: valid=%b sum=%h ovf=%b unf=%b id=%0d expected 1 %h %b %b %0d",
               w_valid, w_sum, w_ovf, w_unf, w_id, ews, wo, wu, w);
    end

    for (int i = 0; i < hold; i++) begin
      req_valid = N'($urandom);
      rsp_ready = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== '0 || rsp_sum !== es || rsp_id !== 2'(w) ||
          rsp_overflow !== eo || rsp_underflow !== eu) begin
        errors++;
        $display("[TB] FAIL hold: valid=%b ready=%b sum=%h id=%0d ovf=%b unf=%b expected 1 0000 %h %0d %b %b",
                 rsp_valid, req_ready, rsp_sum, rsp_id, rsp_overflow, rsp_underflow, es, w, eo, eu);
      end
    end
    rsp_ready = 1'b1;
    req_valid = keep_valid ? v : '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = 4'hF; rsp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ready: req_ready=%b expected 0000", req_ready);
    end
    @(negedge clk);
    #1;
    reset = 1'b0; req_valid = '0;
    m_last = N - 1; m_count = 0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_sum !== 16'h0 || rsp_id !== 2'd0 || rsp_overflow !== 1'b0 ||
        rsp_underflow !== 1'b0 || ovf_count !== 16'h0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: valid=%b sum=%h id=%0d ovf=%b unf=%b cnt=%0d busy=%b expected all 0",
               rsp_valid, rsp_sum, rsp_id, rsp_overflow, rsp_underflow, ovf_count, busy);
    end
  endtask

  task automatic test_single();
    run_txn(4'b0001, {48'h0, 16'h2000}, {48'h0, 16'h1000}, 0, 1'b0);
  endtask

  task automatic test_overflow();
    run_txn(4'b0010, {4{16'h4000}}, {4{16'h4000}}, 0, 1'b0);
  endtask

  task automatic test_underflow();
    run_txn(4'b0100, {4{16'hA000}}, {4{16'hA000}}, 0, 1'b0);
    run_txn(4'b1000, {4{16'h7FFF}}, {4{16'h8001}}, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_txn(4'b0011, {4{16'h1234}}, {4{16'h0111}}, 5, 1'b0);
  endtask

  task automatic test_fairness();
    test_reset();
    for (int k = 0; k < 5; k++) begin
      run_txn(4'hF, {16'h0400, 16'h0300, 16'h0200, 16'h0100},
              {16'h0040, 16'h0030, 16'h0020, 16'h0010}, 0, 1'b1);
      checks++;
      if (obs_id !== 2'(k % N) || (k > 0 && hs_gap != 3)) begin
        errors++;
        $display("[TB] FAIL fairness: id=%0d gap=%0d expected id %0d gap 3", obs_id, hs_gap, k % N);
      end
    end
  endtask

  task automatic test_reset_mid();
    run_txn(4'b0100, {4{16'h6000}}, {4{16'h3000}}, 0, 1'b0);
    @(negedge clk);
    req_valid = 4'hF; req_a = {4{16'h0001}}; req_b = {4{16'h0002}}; rsp_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || req_ready !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_mid_add: busy=%b ready=%b expected 1 0000", busy, req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || ovf_count !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_idle: busy=%b valid=%b cnt=%0d expected 0 0 0", busy, rsp_valid, ovf_count);
    end
    reset = 1'b0; req_valid = '0;
    m_last = N - 1; m_count = 0;
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_norsp: rsp_valid=%b expected 0", rsp_valid);
    end
    run_txn(4'hF, {4{16'h0005}}, {4{16'h0006}}, 0, 1'b0);
    checks++;
    if (obs_id !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_grant: id=%0d expected 0", obs_id);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    logic [N*W-1:0] a, b;
    for (int t = 0; t < 40; t++) begin
      v = N'($urandom_range(1, 15));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      run_txn(v, a, b, $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_underflow();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    test_random();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
